register_file: RTL and testbench
================================

// Module: register_file
// PURPOSE
//  Parametrised multi-entry register storage with one write port and NREAD synchronous read ports.
//  Successor to the single-entry register primitive: adds depth, multiple read channels,
//  optional write-to-read bypass and a bulk clear.
//  Sits in the core primitive library as the storage element behind Filament-generated
//  state banks and small scratchpads.
// PARAMETERS
//  WIDTH     32  data bits per entry
//  DEPTH     8   number of entries (>=2; need not be a power of two)
//  NREAD     2   number of independent read ports (>=1)
//  BYPASS    1   1: same-cycle write is forwarded to a matching read; 0: read returns old data
//  RESET_VAL 0   value loaded into every entry on reset/clear (WIDTH bits)
//  localparam AW = $clog2(DEPTH) (min 1)
// PORTS
//  clk         in   1           clock, all state updates on posedge
//  reset       in   1           synchronous, active-high
//  clear       in   1           synchronous bulk clear of all entries to RESET_VAL
//  write_en    in   1           write strobe
//  write_addr  in   AW          write entry index
//  in          in   WIDTH       write data
//  read_en     in   NREAD       per-port read strobe; bit p controls port p
//  read_addr   in   NREAD*AW    packed read indices; port p at [p*AW +: AW]
//  out         out  NREAD*WIDTH packed read data; port p at [p*WIDTH +: WIDTH]
// BEHAVIOUR
//  - Reset: all entries <= RESET_VAL; all out slices <= 0. Reset overrides every other input.
//  - Write: write_en=1 and write_addr<DEPTH -> entry[write_addr] <= in at next edge.
//    write_addr>=DEPTH -> write silently dropped, no entry changes.
//  - Read latency 1: read_en[p]=1 in cycle t -> out slice p valid from edge t+1 and held.
//    read_en[p]=0 -> out slice p holds its previous value (no X, no change).
//    read_addr[p]>=DEPTH with read_en[p]=1 -> out slice p <= 0.
//  - Simultaneous read/write, same addr, cycle t (valid addr, no clear):
//    BYPASS=1 -> out gets the new value `in`; BYPASS=0 -> out gets the pre-write entry value.
//  - Several ports may read the same or different addresses in one cycle; ports are fully
//    independent, no arbitration, no stalls.
//  - clear=1: all entries <= RESET_VAL at next edge; a write in the same cycle is dropped
//    (clear wins). Reads in the clear cycle return pre-clear contents (no bypass of the
//    dropped write). Out registers are not cleared by clear, only by reset.
//  - Reset asserted mid-stream: takes effect at the next edge regardless of write_en,
//    read_en or clear. The first read after reset deasserts returns RESET_VAL.
//  - No internal state machine beyond storage and output registers; no combinational path
//    from any input to out.
// TESTING
//  1. Reset, then read_en=2'b11, read_addr={3,0} -> next cycle out={RESET_VAL,RESET_VAL}; both out slices 0 during reset.
//  2. Write 0xA5A5_0001 to addr 2, next cycle read port0 addr 2 -> out[31:0]=0xA5A5_0001 one cycle later.
//  3. Entry 5 holds 0x11; same cycle write 0x22 to addr 5 and read port1 addr 5 -> out[63:32]=0x22 (BYPASS=1), =0x11 (BYPASS=0).
//  4. Fill entries 0..7 with i*3; assert clear and write 0x99 to addr 1 together -> all entries read RESET_VAL afterwards; 0x99 never observed.
//  5. DEPTH=6: write 0x77 to addr 7 -> no entry changed (read 0..5 unchanged); read addr 6 -> out slice 0.
//  6. read_en=0 for 4 cycles while writing the addressed entry -> out holds last value; reset mid-stream -> out=0, entries=RESET_VAL.

Source files
------------

// File: rtl/register_file.sv
// rtl/register_file.sv - multi-entry register storage, one write port, NREAD registered read ports
// Bulk clear and optional write-to-read forwarding; every out slice comes straight from a flop.
module register_file #(
  parameter int unsigned          WIDTH     = 32,
  parameter int unsigned          DEPTH     = 8,
  parameter int unsigned          NREAD     = 2,
  parameter bit                   BYPASS    = 1'b1,
  parameter logic [WIDTH-1:0]     RESET_VAL = '0,
  localparam int unsigned         AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clear,
  input  logic                    write_en,
  input  logic [AW-1:0]           write_addr,
  input  logic [WIDTH-1:0]        in,
  input  logic [NREAD-1:0]        read_en,
  input  logic [NREAD*AW-1:0]     read_addr,
  output logic [NREAD*WIDTH-1:0]  out
);

  logic [WIDTH-1:0]             mem_q [DEPTH];
  logic [WIDTH-1:0]             mem_d [DEPTH];
  logic [NREAD-1:0][WIDTH-1:0]  out_q;
  logic [NREAD-1:0][WIDTH-1:0]  out_d;

  logic write_hit;

  // A write lands only when it targets a real entry and is not overridden by clear.
  assign write_hit = write_en && !clear && (int'(write_addr) < int'(DEPTH));

  always_comb begin
    mem_d = mem_q;
    if (clear) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_d[i] = RESET_VAL;
      end
    end else if (write_hit) begin
      mem_d[write_addr] = in;
    end
  end

  always_comb begin
    out_d = out_q;
    for (int p = 0; p < int'(NREAD); p++) begin
      if (read_en[p]) begin
        if (int'(read_addr[p*AW +: AW]) >= int'(DEPTH)) begin
          out_d[p] = '0;
        end else if (BYPASS && write_hit && (write_addr == read_addr[p*AW +: AW])) begin
          out_d[p] = in;
        end else begin
          out_d[p] = mem_q[read_addr[p*AW +: AW]];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= RESET_VAL;
      end
      out_q <= '0;
    end else begin
      mem_q <= mem_d;
      out_q <= out_d;
    end
  end

  assign out = out_q;

endmodule

// File: tb/tb_register_file.sv
// tb/tb_register_file.sv - randomized bench for register_file against an array-based reference model
// Three instances share stimulus: DEPTH 8 with and without forwarding, and DEPTH 6.
module tb_register_file;

  localparam logic [31:0] RV = 32'h5EED_0001;

  logic        clk = 1'b0;
  logic        reset;
  logic        clear;
  logic        write_en;
  logic [2:0]  write_addr;
  logic [31:0] din;
  logic [1:0]  read_en;
  logic [5:0]  read_addr;
  logic [63:0] out8, out8n, out6;
  logic [63:0] outs [3];

  int passed = 0;
  int total  = 0;

  logic [31:0] m8 [8];
  logic [31:0] m6 [6];
  logic [31:0] e8 [2];
  logic [31:0] e8n [2];
  logic [31:0] e6 [2];

  always #5 clk = ~clk;

  register_file #(.WIDTH(32), .DEPTH(8), .NREAD(2), .BYPASS(1'b1), .RESET_VAL(RV)) u8 (
    .clk(clk), .reset(reset), .clear(clear), .write_en(write_en), .write_addr(write_addr),
    .in(din), .read_en(read_en), .read_addr(read_addr), .out(out8));

  register_file #(.WIDTH(32), .DEPTH(8), .NREAD(2), .BYPASS(1'b0), .RESET_VAL(RV)) u8n (
    .clk(clk), .reset(reset), .clear(clear), .write_en(write_en), .write_addr(write_addr),
    .in(din), .read_en(read_en), .read_addr(read_addr), .out(out8n));

  register_file #(.WIDTH(32), .DEPTH(6), .NREAD(2), .BYPASS(1'b1), .RESET_VAL(RV)) u6 (
    .clk(clk), .reset(reset), .clear(clear), .write_en(write_en), .write_addr(write_addr),
    .in(din), .read_en(read_en), .read_addr(read_addr), .out(out6));

  assign outs[0] = out8;
  assign outs[1] = out8n;
  assign outs[2] = out6;

  function automatic logic [63:0] expv(input int i);
    if (i == 0) return {e8[1], e8[0]};
    if (i == 1) return {e8n[1], e8n[0]};
    return {e6[1], e6[0]};
  endfunction

  // Apply the current inputs to the model, as the next clock edge will to the DUTs.
  task automatic step();
    int a;
    for (int p = 0; p < 2; p++) begin
      a = int'(read_addr[p*3 +: 3]);
      if (reset) begin
        e8[p] = 0; e8n[p] = 0; e6[p] = 0;
      end else if (read_en[p]) begin
        e8n[p] = m8[a];
        e8[p]  = (write_en && !clear && write_addr == a) ? din : m8[a];
        if (a >= 6) e6[p] = 0;
        else        e6[p] = (write_en && !clear && write_addr == a) ? din : m6[a];
      end
    end
    if (reset || clear) begin
      for (int i = 0; i < 8; i++) m8[i] = RV;
      for (int i = 0; i < 6; i++) m6[i] = RV;
    end else if (write_en) begin
      m8[write_addr] = din;
      if (write_addr < 6) m6[write_addr] = din;
    end
  endtask

  task automatic cycle();
    step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    reset = 0; clear = 0; write_en = 0; read_en = 0;
    write_addr = 3'($urandom); din = $urandom; read_addr = 6'($urandom);
  endtask

  task automatic do_write(input int a, input logic [31:0] d);
    idle(); write_en = 1; write_addr = 3'(a); din = d;
    cycle();
  endtask

  task automatic test_reset();
    idle(); reset = 1; write_en = 1; read_en = 2'b11; clear = 1'($urandom);
    cycle(); cycle();
    for (int i = 0; i < 3; i++) begin
      total++;
      if (outs[i] !== 64'h0) $display("FAIL reset_out inst%0d got %h want %h", i, outs[i], 64'h0);
      else passed++;
    end
    idle(); read_en = 2'b11; read_addr = {3'd3, 3'd0};
    cycle();
    for (int i = 0; i < 3; i++) begin
      total++;
      if (outs[i] !== {RV, RV}) $display("FAIL first_read inst%0d got %h want %h", i, outs[i], {RV, RV});
      else passed++;
    end
  endtask

  task automatic test_write_read();
    do_write(2, 32'hA5A5_0001);
    idle(); read_en = 2'b01; read_addr = {3'd6, 3'd2};
    cycle();
    total++;
    if (out8[31:0] !== 32'hA5A5_0001) $display("FAIL write_read got %h want %h", out8[31:0], 32'hA5A5_0001);
    else passed++;
    for (int i = 0; i < 3; i++) begin
      total++;
      if (outs[i] !== expv(i)) $display("FAIL write_read_model inst%0d got %h want %h", i, outs[i], expv(i));
      else passed++;
    end
  endtask

  task automatic test_bypass();
    do_write(5, 32'h11);
    idle(); write_en = 1; write_addr = 3'd5; din = 32'h22; read_en = 2'b10; read_addr = {3'd5, 3'd0};
    cycle();
    total++;
    if (out8[63:32] !== 32'h22) $display("FAIL bypass_on got %h want %h", out8[63:32], 32'h22);
    else passed++;
    total++;
    if (out8n[63:32] !== 32'h11) $display("FAIL bypass_off got %h want %h", out8n[63:32], 32'h11);
    else passed++;
    total++;
    if (out6 !== expv(2)) $display("FAIL bypass_d6 got %h want %h", out6, expv(2));
    else passed++;
  endtask

  task automatic test_clear();
    for (int i = 0; i < 8; i++) do_write(i, 32'(i * 3));
    idle(); clear = 1; write_en = 1; write_addr = 3'd1; din = 32'h99; read_en = 2'b11; read_addr = {3'd1, 3'd1};
    cycle();
    total++;
    if (out8 !== {32'd3, 32'd3}) $display("FAIL clear_cycle_read got %h want %h", out8, {32'd3, 32'd3});
    else passed++;
    for (int a = 0; a < 8; a += 2) begin
      idle(); read_en = 2'b11; read_addr = {3'(a + 1), 3'(a)};
      cycle();
      for (int i = 0; i < 3; i++) begin
        total++;
        if (outs[i] !== expv(i)) $display("FAIL clear_read inst%0d addr%0d got %h want %h", i, a, outs[i], expv(i));
        else passed++;
      end
      total++;
      if (out8 !== {RV, RV}) $display("FAIL clear_val addr%0d got %h want %h", a, out8, {RV, RV});
      else passed++;
    end
  endtask

  task automatic test_depth6();
    for (int i = 0; i < 6; i++) do_write(i, $urandom);
    do_write(7, 32'h77);
    for (int a = 0; a < 8; a += 2) begin
      idle(); read_en = 2'b11; read_addr = {3'(a + 1), 3'(a)};
      cycle();
      total++;
      if (out6 !== expv(2)) $display("FAIL depth6_read addr%0d got %h want %h", a, out6, expv(2));
      else passed++;
    end
    total++;
    if (out6 !== 64'h0) $display("FAIL depth6_oob got %h want %h", out6, 64'h0);
    else passed++;
  endtask

  task automatic test_hold();
    logic [63:0] held [3];
    do_write(4, 32'hC0DE_0004);
    idle(); read_en = 2'b11; read_addr = {3'd4, 3'd4};
    cycle();
    for (int i = 0; i < 3; i++) held[i] = expv(i);
    for (int c = 0; c < 4; c++) begin
      idle(); write_en = 1; write_addr = 3'd4; din = $urandom; read_addr = {3'd4, 3'd4};
      cycle();
      for (int i = 0; i < 3; i++) begin
        total++;
        if (outs[i] !== held[i]) $display("FAIL hold inst%0d cyc%0d got %h want %h", i, c, outs[i], held[i]);
        else passed++;
      end
    end
    idle(); reset = 1; write_en = 1; clear = 1; read_en = 2'b11;
    cycle();
    for (int i = 0; i < 3; i++) begin
      total++;
      if (outs[i] !== 64'h0) $display("FAIL midreset inst%0d got %h want %h", i, outs[i], 64'h0);
      else passed++;
    end
    idle(); read_en = 2'b11; read_addr = {3'd4, 3'd2};
    cycle();
    for (int i = 0; i < 3; i++) begin
      total++;
      if (outs[i] !== {RV, RV}) $display("FAIL post_reset inst%0d got %h want %h", i, outs[i], {RV, RV});
      else passed++;
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      reset      = ($urandom_range(0, 99) < 2);
      clear      = ($urandom_range(0, 99) < 5);
      write_en   = ($urandom_range(0, 99) < 60);
      write_addr = 3'($urandom);
      din        = $urandom;
      read_en    = 2'($urandom);
      read_addr  = ($urandom_range(0, 3) == 0) ? {2{write_addr}} : 6'($urandom);
      cycle();
      for (int i = 0; i < 3; i++) begin
        total++;
        if (outs[i] !== expv(i)) $display("FAIL random inst%0d cyc%0d got %h want %h", i, c, outs[i], expv(i));
        else passed++;
      end
    end
  endtask

  initial begin
    for (int p = 0; p < 2; p++) begin
      e8[p] = 0; e8n[p] = 0; e6[p] = 0;
    end
    idle();
    test_reset();
    test_write_read();
    test_bypass();
    test_clear();
    test_depth6();
    test_hold();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
